hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/flush controller for the 5-stage pipeline: drives the stall/clear inputs of the IF/ID, ID/EX,
//  EX/MEM pipeline registers (incl. the decode->execute control register's clear) and the EX forwarding muxes.
//  Detects load-use and taken branch/jump hazards; freezes the pipeline on a data-memory wait handshake
//  with a timeout FSM; keeps saturating stall/flush performance counters.
// PARAMETERS
//  ADDR_WIDTH  5   register-file address width
//  MAX_WAIT    15  max consecutive MEM_WAIT cycles before timeout (>=1)
//  STAT_WIDTH  16  width of performance counters
// PORTS
//  clk          in   1           system clock, rising edge
//  reset        in   1           asynchronous, active-low reset (asserted when 0)
//  Rs1D,Rs2D    in   ADDR_WIDTH  source regs of instruction in Decode
//  Rs1E,Rs2E    in   ADDR_WIDTH  source regs of instruction in Execute
//  RdE          in   ADDR_WIDTH  dest reg in Execute
//  ResultSrcE   in   2           2'b01 = load in Execute
//  PCSrcE       in   1           taken branch/jump resolved in Execute
//  RegWriteM,RdM in  1,ADDR_WIDTH writeback info, Memory stage
//  RegWriteW,RdW in  1,ADDR_WIDTH writeback info, Writeback stage
//  MemReqM      in   1           data-memory access in Memory stage
//  MemReadyM    in   1           data memory completes access this cycle
//  stat_clr     in   1           synchronous clear of counters
//  StallF,StallD,StallE,StallM out 1  hold PC / IF-ID / ID-EX / EX-MEM registers
//  FlushD,FlushE out 1           clear IF-ID / ID-EX registers (bubble)
//  ForwardAE,ForwardBE out 2     00 regfile, 01 from W, 10 from M
//  mem_timeout  out  1           sticky: memory wait exceeded MAX_WAIT
//  stall_cycles out  STAT_WIDTH  cycles with StallF=1, saturating
//  flush_count  out  STAT_WIDTH  taken-control-flow flushes, saturating
// BEHAVIOUR
//  Reset (reset=0, async): state=RUN, wait_cnt=0, mem_timeout=0, counters=0; all Stall*/Flush*=0, Forward*=00.
//  Forwarding (comb): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 &&
//   RdW==Rs1E; else 00. ForwardBE same with Rs2E. M beats W.
//  lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  memwait = MemReqM && !MemReadyM.
//  freeze = memwait || state==ERROR. While freeze: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0
//   (freeze overrides every other hazard; stalled stages keep contents).
//  Else: StallE=StallM=0; FlushD=PCSrcE; FlushE=PCSrcE||lwStall; StallF=StallD=lwStall && !PCSrcE
//   (taken branch wins: PC must load target, load bubble not needed).
//  FSM (registered, wait_cnt width clog2(MAX_WAIT+1)):
//   RUN:      memwait -> MEM_WAIT, wait_cnt<=1; else stay.
//   MEM_WAIT: !memwait -> RUN, wait_cnt<=0; else wait_cnt==MAX_WAIT -> ERROR; else wait_cnt++.
//   ERROR:    terminal until reset; mem_timeout<=1 (visible the cycle after entry).
//   Ready in the same cycle wait_cnt==MAX_WAIT -> RUN (ready wins). ERROR reached after MAX_WAIT+1
//   consecutive not-ready cycles. Zero-wait access (MemReadyM=1) never leaves RUN, no stall.
//  Counters: stall_cycles++ each cycle StallF=1; flush_count++ each cycle PCSrcE=1 && !freeze.
//   Saturate at all-ones; stat_clr=1 -> 0 next edge (clear beats increment). Counters run in ERROR.
//  Reset mid-wait: FSM -> RUN, mem_timeout -> 0 immediately; outputs 0 while reset=0.
// TESTING
//  1 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; RdM=0 -> 01; RegWriteW=0 -> 00.
//  2 Load RdE=7, ResultSrcE=01, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0; RdE=0 -> all 0.
//  3 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0; flush_count +1.
//  4 MemReqM=1, MemReadyM=0 for 4 cycles then 1 -> all Stall*=1 for 4 cycles, Flush*=0 despite PCSrcE=1,
//    state back to RUN, stall_cycles=4.
//  5 MAX_WAIT=15, MemReadyM=0 for 16 cycles -> ERROR, mem_timeout=1 on cycle 17, Stall* stuck 1;
//    ready on 16th cycle instead -> RUN, no timeout.
//  6 reset=0 during MEM_WAIT -> outputs 0, mem_timeout 0 async; stall_cycles preset to 0xFFFF + stall -> holds 0xFFFF; stat_clr -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: forwarding selects, load-use and control-flow
// bubbles, memory-wait freeze with timeout FSM, and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 15,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    input  logic [ADDR_WIDTH-1:0] Rs1E,
    input  logic [ADDR_WIDTH-1:0] Rs2E,
    input  logic [ADDR_WIDTH-1:0] RdE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic                  RegWriteM,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic                  RegWriteW,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    input  logic                  stat_clr,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  mem_timeout,
    output logic [STAT_WIDTH-1:0] stall_cycles,
    output logic [STAT_WIDTH-1:0] flush_count
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]        WAIT_MAX = WCW'(MAX_WAIT);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [STAT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [STAT_WIDTH-1:0] flush_count_q, flush_count_d;

    logic memwait;
    logic lw_stall;
    logic freeze;

    // Memory stage has priority over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_WIDTH-1:0] rs,
        input logic                  wr_m,
        input logic [ADDR_WIDTH-1:0] rd_m,
        input logic                  wr_w,
        input logic [ADDR_WIDTH-1:0] rd_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(
        input logic [STAT_WIDTH-1:0] cnt,
        input logic                  clr,
        input logic                  inc
    );
        logic [STAT_WIDTH-1:0] nxt;
        nxt = cnt;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cnt != STAT_MAX)) begin
            nxt = cnt + STAT_WIDTH'(1);
        end
        return nxt;
    endfunction

    assign memwait  = MemReqM && !MemReadyM;
    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign freeze   = memwait || (state_q == ERROR);

    // Hazard outputs are forced low while reset is asserted.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else begin
                FlushD = PCSrcE;
                FlushE = PCSrcE || lw_stall;
                StallF = lw_stall && !PCSrcE;
                StallD = lw_stall && !PCSrcE;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (memwait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (!memwait) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_timeout_d = mem_timeout_q || (state_d == ERROR);
    end

    always_comb begin
        stall_cycles_d = sat_inc(stall_cycles_q, stat_clr, StallF);
        flush_count_d  = sat_inc(flush_count_q, stat_clr, PCSrcE && !freeze);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush, memory-wait freeze/timeout,
// async reset and counter saturation (a narrow-counter instance shows the saturation corner).
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM, stat_clr;

    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cycles, flush_count;

    logic        s_StallF, s_StallD, s_StallE, s_StallM, s_FlushD, s_FlushE, s_mem_timeout;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic [3:0]  s_stall_cycles, s_flush_count;

    int nvec;
    int nerr;

    hazard_ctrl #(.ADDR_WIDTH(5), .MAX_WAIT(15), .STAT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RdM(RdM),
        .RegWriteW(RegWriteW), .RdW(RdW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .stat_clr(stat_clr), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_ctrl #(.ADDR_WIDTH(5), .MAX_WAIT(15), .STAT_WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RdM(RdM),
        .RegWriteW(RegWriteW), .RdW(RdW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .stat_clr(stat_clr), .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE),
        .StallM(s_StallM), .FlushD(s_FlushD), .FlushE(s_FlushE), .ForwardAE(s_ForwardAE),
        .ForwardBE(s_ForwardBE), .mem_timeout(s_mem_timeout), .stall_cycles(s_stall_cycles),
        .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b1; stat_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        RdE = 5'd7; Rs2D = 5'd7; ResultSrcE = 2'b01; MemReqM = 1'b1; MemReadyM = 1'b0;
        #3;
        nvec++; if (StallF !== 1'b0) begin nerr++; $display("FAIL rst_StallF got %b want 0", StallF); end
        nvec++; if (StallM !== 1'b0) begin nerr++; $display("FAIL rst_StallM got %b want 0", StallM); end
        nvec++; if (FlushE !== 1'b0) begin nerr++; $display("FAIL rst_FlushE got %b want 0", FlushE); end
        nvec++; if (ForwardAE !== 2'b00) begin nerr++; $display("FAIL rst_ForwardAE got %b want 00", ForwardAE); end
        nvec++; if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL rst_timeout got %b want 0", mem_timeout); end
        nvec++; if (stall_cycles !== 16'd0) begin nerr++; $display("FAIL rst_stall_cycles got %0d want 0", stall_cycles); end
        nvec++; if (flush_count !== 16'd0) begin nerr++; $display("FAIL rst_flush_count got %0d want 0", flush_count); end
        idle();
        #9 reset = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        idle();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
        #1;
        nvec++; if (ForwardAE !== 2'b10) begin nerr++; $display("FAIL fwdA_M got %b want 10", ForwardAE); end
        RdM = 5'd0; #1;
        nvec++; if (ForwardAE !== 2'b01) begin nerr++; $display("FAIL fwdA_W got %b want 01", ForwardAE); end
        RegWriteW = 1'b0; #1;
        nvec++; if (ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwdA_none got %b want 00", ForwardAE); end
        Rs1E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; #1;
        nvec++; if (ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwdA_x0 got %b want 00", ForwardAE); end
        idle();
        Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b1; RdW = 5'd9; RegWriteW = 1'b1; #1;
        nvec++; if (ForwardBE !== 2'b10) begin nerr++; $display("FAIL fwdB_M got %b want 10", ForwardBE); end
        nvec++; if (ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwdA_cross got %b want 00", ForwardAE); end
        RegWriteM = 1'b0; #1;
        nvec++; if (ForwardBE !== 2'b01) begin nerr++; $display("FAIL fwdB_W got %b want 01", ForwardBE); end
        RdW = 5'd3; #1;
        nvec++; if (ForwardBE !== 2'b00) begin nerr++; $display("FAIL fwdB_none got %b want 00", ForwardBE); end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        RdE = 5'd7; ResultSrcE = 2'b01; Rs2D = 5'd7; #1;
        nvec++; if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin nerr++;
            $display("FAIL lwstall got F%b D%b FE%b FD%b want 1110", StallF, StallD, FlushE, FlushD); end
        nvec++; if ({StallE, StallM} !== 2'b00) begin nerr++; $display("FAIL lwstall_EM got %b want 00", {StallE, StallM}); end
        RdE = 5'd0; Rs2D = 5'd0; #1;
        nvec++; if ({StallF, StallD, FlushE, FlushD} !== 4'b0000) begin nerr++;
            $display("FAIL lw_rd0 got %b want 0000", {StallF, StallD, FlushE, FlushD}); end
        RdE = 5'd4; Rs1D = 5'd4; #1;
        nvec++; if ({StallF, FlushE} !== 2'b11) begin nerr++; $display("FAIL lw_rs1 got %b want 11", {StallF, FlushE}); end
        ResultSrcE = 2'b10; #1;
        nvec++; if ({StallF, FlushE} !== 2'b00) begin nerr++; $display("FAIL nonload got %b want 00", {StallF, FlushE}); end
        idle();
    endtask

    task automatic test_branch();
        idle();
        clear_stats();
        PCSrcE = 1'b1; RdE = 5'd7; ResultSrcE = 2'b01; Rs2D = 5'd7; #1;
        nvec++; if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin nerr++;
            $display("FAIL br_lw got %b want 1100", {FlushD, FlushE, StallF, StallD}); end
        tick();
        idle(); #1;
        nvec++; if (flush_count !== 16'd1) begin nerr++; $display("FAIL br_flush_count got %0d want 1", flush_count); end
        nvec++; if (stall_cycles !== 16'd0) begin nerr++; $display("FAIL br_stall_cycles got %0d want 0", stall_cycles); end
    endtask

    task automatic test_mem_wait();
        idle();
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1; #1;
            nvec++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin nerr++;
                $display("FAIL memwait_c%0d got %b want 111100", i, {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
            tick();
        end
        MemReadyM = 1'b1; PCSrcE = 1'b0; #1;
        nvec++; if ({StallF, StallM} !== 2'b00) begin nerr++; $display("FAIL memready got %b want 00", {StallF, StallM}); end
        tick();
        idle(); #1;
        nvec++; if (stall_cycles !== 16'd4) begin nerr++; $display("FAIL mw_stall_cycles got %0d want 4", stall_cycles); end
        nvec++; if (flush_count !== 16'd0) begin nerr++; $display("FAIL mw_flush_count got %0d want 0", flush_count); end
        tick();
        nvec++; if ({StallF, mem_timeout} !== 2'b00) begin nerr++; $display("FAIL mw_run got %b want 00", {StallF, mem_timeout}); end
    endtask

    task automatic test_timeout();
        idle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        MemReadyM = 1'b1; #1;
        nvec++; if (StallF !== 1'b0) begin nerr++; $display("FAIL ready16 got %b want 0", StallF); end
        tick();
        idle(); tick();
        nvec++; if ({StallF, mem_timeout} !== 2'b00) begin nerr++; $display("FAIL ready16_run got %b want 00", {StallF, mem_timeout}); end
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        nvec++; if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL to_early got %b want 0", mem_timeout); end
        tick();
        MemReadyM = 1'b1; PCSrcE = 1'b1; #1;
        nvec++; if (mem_timeout !== 1'b1) begin nerr++; $display("FAIL to_c17 got %b want 1", mem_timeout); end
        nvec++; if ({StallF, StallD, StallE, StallM, FlushD, FlushE} !== 6'b111100) begin nerr++;
            $display("FAIL err_freeze got %b want 111100", {StallF, StallD, StallE, StallM, FlushD, FlushE}); end
        clear_stats();
        idle();
        for (int i = 0; i < 3; i++) tick();
        nvec++; if (stall_cycles !== 16'd3) begin nerr++; $display("FAIL err_count got %0d want 3", stall_cycles); end
        nvec++; if ({StallF, mem_timeout} !== 2'b11) begin nerr++; $display("FAIL err_sticky got %b want 11", {StallF, mem_timeout}); end
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        #2 reset = 1'b0;
        #1;
        nvec++; if ({mem_timeout, StallF, StallM} !== 3'b000) begin nerr++; $display("FAIL err_rst got %b want 000", {mem_timeout, StallF, StallM}); end
        nvec++; if (ForwardAE !== 2'b00) begin nerr++; $display("FAIL err_rst_fwd got %b want 00", ForwardAE); end
        nvec++; if (stall_cycles !== 16'd0) begin nerr++; $display("FAIL err_rst_cnt got %0d want 0", stall_cycles); end
        idle();
        #4 reset = 1'b1;
        tick();
        nvec++; if (StallF !== 1'b0) begin nerr++; $display("FAIL post_rst got %b want 0", StallF); end
    endtask

    task automatic test_reset_mid_wait();
        idle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        #2 reset = 1'b0;
        #1;
        nvec++; if ({StallF, StallD, StallE, StallM} !== 4'b0000) begin nerr++;
            $display("FAIL mid_rst got %b want 0000", {StallF, StallD, StallE, StallM}); end
        idle();
        #4 reset = 1'b1;
        tick();
        MemReqM = 1'b1; MemReadyM = 1'b1; #1;
        nvec++; if ({StallF, mem_timeout} !== 2'b00) begin nerr++; $display("FAIL zero_wait got %b want 00", {StallF, mem_timeout}); end
        tick();
        idle();
    endtask

    task automatic test_saturate();
        idle();
        clear_stats();
        RdE = 5'd7; ResultSrcE = 2'b01; Rs1D = 5'd7;
        for (int i = 0; i < 20; i++) tick();
        nvec++; if (s_stall_cycles !== 4'hF) begin nerr++; $display("FAIL sat_stall got %0h want f", s_stall_cycles); end
        nvec++; if (stall_cycles !== 16'd20) begin nerr++; $display("FAIL wide_stall got %0d want 20", stall_cycles); end
        idle();
        PCSrcE = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        nvec++; if (s_flush_count !== 4'hF) begin nerr++; $display("FAIL sat_flush got %0h want f", s_flush_count); end
        nvec++; if (flush_count !== 16'd17) begin nerr++; $display("FAIL wide_flush got %0d want 17", flush_count); end
        nvec++; if (s_stall_cycles !== 4'hF) begin nerr++; $display("FAIL sat_hold got %0h want f", s_stall_cycles); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0; PCSrcE = 1'b0;
        nvec++; if ({s_flush_count, s_stall_cycles} !== 8'h00) begin nerr++;
            $display("FAIL sat_clr got %0h want 00", {s_flush_count, s_stall_cycles}); end
        nvec++; if (flush_count !== 16'd0) begin nerr++; $display("FAIL clr_beats_inc got %0d want 0", flush_count); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
